// File: rtl/ram4r_sched_pkg.sv
// Shared types for the 4-read/1-write RAM scheduler.
// Optional build macro used by the top: RAM4R_BYPASS_EN (write-first read bypass).
package ram4r_sched_pkg;

    localparam int NUM_RD_PORTS = 4;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef logic [$clog2(NUM_RD_PORTS)-1:0] port_idx_t;

endpackage

// File: rtl/rr_multi_grant.sv
// Combinational round-robin picker: scans from ptr_i and grants the first
// NUM_RD_PORTS valid requesters, reporting which requester landed on each port.
module rr_multi_grant
    import ram4r_sched_pkg::*;
#(
    parameter  int NUM_REQ = 8,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]      valid_i,
    input  logic [IW-1:0]           ptr_i,
    output logic [NUM_REQ-1:0]      grant_o,
    output logic [NUM_RD_PORTS-1:0] port_vld_o,
    output logic [IW-1:0]           port_req_o [NUM_RD_PORTS],
    output logic [IW-1:0]           next_ptr_o
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    logic [2:0]    n_grant;

    always_comb begin
        grant_o    = '0;
        port_vld_o = '0;
        next_ptr_o = ptr_i;
        sum        = '0;
        idx        = '0;
        n_grant    = '0;
        for (int k = 0; k < NUM_RD_PORTS; k++) begin
            port_req_o[k] = '0;
        end
        for (int off = 0; off < NUM_REQ; off++) begin
            // ptr + off stays below 2*NUM_REQ, so one conditional subtract wraps it.
            sum = {1'b0, ptr_i} + (IW+1)'(off);
            if (sum >= (IW+1)'(NUM_REQ)) begin
                sum = sum - (IW+1)'(NUM_REQ);
            end
            idx = sum[IW-1:0];
            if (valid_i[idx] && (n_grant < 3'(NUM_RD_PORTS))) begin
                grant_o[idx]                     = 1'b1;
                port_vld_o[port_idx_t'(n_grant)] = 1'b1;
                port_req_o[port_idx_t'(n_grant)] = idx;
                n_grant                          = n_grant + 3'd1;
                next_ptr_o = (idx == IW'(NUM_REQ-1)) ? '0 : idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_4r1w_sched.sv
// Arbitrates NUM_REQ readers plus one writer onto a 4R1W RAM after zero-filling it.
// Build macro: RAM4R_BYPASS_EN selects write-first data for same-cycle read/write collisions.
module ram_4r1w_sched
    import ram4r_sched_pkg::*;
#(
    parameter  int BLOCKSIZE = 10,
    parameter  int NUM_REQ   = 8,
    parameter  int DW        = 32,
    localparam int AW        = BLOCKSIZE + 1,
    localparam int IW        = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    rd_valid,
    input  logic [NUM_REQ*AW-1:0] rd_addr,
    output logic [NUM_REQ-1:0]    rd_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [NUM_REQ*DW-1:0] rsp_data,
    input  logic                  wr_valid,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DW-1:0]         wr_data,
    output logic                  wr_ready,
    output logic                  init_done,
    output logic [AW-1:0]         r_addr_1,
    output logic [AW-1:0]         r_addr_2,
    output logic [AW-1:0]         r_addr_3,
    output logic [AW-1:0]         r_addr_4,
    input  logic [DW-1:0]         r_dout_1,
    input  logic [DW-1:0]         r_dout_2,
    input  logic [DW-1:0]         r_dout_3,
    input  logic [DW-1:0]         r_dout_4,
    output logic [AW-1:0]         w_addr_1,
    output logic [DW-1:0]         w_din_1,
    output logic                  w_enb_1,
    output state_e                state_dbg
);

    state_e                  state_q, state_d;
    logic [AW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [NUM_RD_PORTS-1:0] rsp_vld_q, rsp_vld_d;
    logic [IW-1:0]           rsp_req_q [NUM_RD_PORTS];
    logic [IW-1:0]           rsp_req_d [NUM_RD_PORTS];

    logic [NUM_REQ-1:0]      req_run;
    logic [NUM_REQ-1:0]      grant;
    logic [NUM_RD_PORTS-1:0] port_vld;
    logic [IW-1:0]           port_req [NUM_RD_PORTS];
    logic [IW-1:0]           next_ptr;
    logic [AW-1:0]           raddr [NUM_RD_PORTS];
    logic [DW-1:0]           rdout [NUM_RD_PORTS];

`ifdef RAM4R_BYPASS_EN
    logic [NUM_RD_PORTS-1:0] byp_hit_q, byp_hit_d;
    logic [DW-1:0]           byp_data_q;
`endif

    assign state_dbg = state_q;
    assign req_run   = (state_q == RUN) ? rd_valid : '0;

    rr_multi_grant #(.NUM_REQ(NUM_REQ)) u_rr (
        .valid_i    (req_run),
        .ptr_i      (rr_ptr_q),
        .grant_o    (grant),
        .port_vld_o (port_vld),
        .port_req_o (port_req),
        .next_ptr_o (next_ptr)
    );

    // Write port is owned by the zero-fill walker in INIT, by the client in RUN.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_done = 1'b0;
        wr_ready  = 1'b0;
        w_enb_1   = 1'b0;
        w_addr_1  = '0;
        w_din_1   = '0;
        case (state_q)
            INIT: begin
                w_enb_1  = ~rst;
                w_addr_1 = cnt_q;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == {AW{1'b1}}) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                init_done = 1'b1;
                wr_ready  = 1'b1;
                w_enb_1   = wr_valid;
                w_addr_1  = wr_addr;
                w_din_1   = wr_data;
            end
        endcase
    end

    always_comb begin
        rd_ready = grant;
        rr_ptr_d = (|grant) ? next_ptr : rr_ptr_q;
        for (int k = 0; k < NUM_RD_PORTS; k++) begin
            raddr[k]     = port_vld[k] ? rd_addr[port_req[k]*AW +: AW] : '0;
            rsp_vld_d[k] = port_vld[k];
            rsp_req_d[k] = port_req[k];
        end
`ifdef RAM4R_BYPASS_EN
        for (int k = 0; k < NUM_RD_PORTS; k++) begin
            byp_hit_d[k] = port_vld[k] && wr_valid && wr_ready && (raddr[k] == wr_addr);
        end
`endif
    end

    assign r_addr_1 = raddr[0];
    assign r_addr_2 = raddr[1];
    assign r_addr_3 = raddr[2];
    assign r_addr_4 = raddr[3];
    assign rdout[0] = r_dout_1;
    assign rdout[1] = r_dout_2;
    assign rdout[2] = r_dout_3;
    assign rdout[3] = r_dout_4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= INIT;
            cnt_q     <= '0;
            rr_ptr_q  <= '0;
            rsp_vld_q <= '0;
            for (int k = 0; k < NUM_RD_PORTS; k++) begin
                rsp_req_q[k] <= '0;
            end
`ifdef RAM4R_BYPASS_EN
            byp_hit_q  <= '0;
            byp_data_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            rsp_vld_q <= rsp_vld_d;
            for (int k = 0; k < NUM_RD_PORTS; k++) begin
                rsp_req_q[k] <= rsp_req_d[k];
            end
`ifdef RAM4R_BYPASS_EN
            byp_hit_q  <= byp_hit_d;
            byp_data_q <= wr_data;
`endif
        end
    end

    // A requester holds at most one port per cycle, so the steering never collides.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        for (int k = 0; k < NUM_RD_PORTS; k++) begin
            if (rsp_vld_q[k]) begin
                rsp_valid[rsp_req_q[k]] = 1'b1;
`ifdef RAM4R_BYPASS_EN
                rsp_data[rsp_req_q[k]*DW +: DW] = byp_hit_q[k] ? byp_data_q : rdout[k];
`else
                rsp_data[rsp_req_q[k]*DW +: DW] = rdout[k];
`endif
            end
        end
    end

endmodule
